// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its key FIFO.
package keypad_pkg;
    localparam int KEY_CODE_W = 4;
    localparam int ROW_N      = 4;
    localparam int COL_N      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ROW_W      = $clog2(ROW_N);
    localparam int COL_W      = $clog2(COL_N);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Index of the lowest set column bit; the lowest column wins when several keys share a row.
    function automatic logic [COL_W-1:0] lowest_col(input logic [COL_N-1:0] c);
        logic [COL_W-1:0] idx;
        idx = '0;
        for (int i = COL_N - 1; i >= 0; i--) begin
            if (c[i]) idx = COL_W'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/key_fifo.sv
// Small key-code FIFO; the head entry is always visible on dout, zero when empty.
module key_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int W     = KEY_CODE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) mem_reg[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row rotation, press/release debounce, one code per press into a FIFO.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ROW_N-1:0]      rows,
    input  logic [COL_N-1:0]      cols,
    input  logic                  read_ack,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_ready,
    output logic                  overflow
);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    state_t            state_reg,    state_next;
    logic [ROW_W-1:0]  row_idx_reg,  row_idx_next;
    logic [COL_W-1:0]  col_idx_reg,  col_idx_next;
    logic [SCAN_W-1:0] scan_cnt_reg, scan_cnt_next;
    logic [DEB_W-1:0]  deb_cnt_reg,  deb_cnt_next;
    logic              overflow_reg;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;

    for (genvar gi = 0; gi < ROW_N; gi++) begin : g_row_drive
        assign rows[gi] = (row_idx_reg == ROW_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= SCAN;
            row_idx_reg  <= '0;
            col_idx_reg  <= '0;
            scan_cnt_reg <= '0;
            deb_cnt_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            row_idx_reg  <= row_idx_next;
            col_idx_reg  <= col_idx_next;
            scan_cnt_reg <= scan_cnt_next;
            deb_cnt_reg  <= deb_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        row_idx_next  = row_idx_reg;
        col_idx_next  = col_idx_reg;
        scan_cnt_next = scan_cnt_reg;
        deb_cnt_next  = deb_cnt_reg;
        push          = 1'b0;
        case (state_reg)
            SCAN: begin
                if (scan_cnt_reg == SCAN_LAST) begin
                    scan_cnt_next = '0;
                    if (cols == '0) begin
                        row_idx_next = row_idx_reg + 1'b1;
                    end else begin
                        col_idx_next = lowest_col(cols);
                        deb_cnt_next = '0;
                        state_next   = DEBOUNCE;
                    end
                end else begin
                    scan_cnt_next = scan_cnt_reg + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (cols[col_idx_reg]) begin
                    if (deb_cnt_reg == DEB_LAST) begin
                        push         = 1'b1;
                        deb_cnt_next = '0;
                        state_next   = HELD;
                    end else begin
                        deb_cnt_next = deb_cnt_reg + 1'b1;
                    end
                end else begin
                    row_idx_next  = row_idx_reg + 1'b1;
                    scan_cnt_next = '0;
                    deb_cnt_next  = '0;
                    state_next    = SCAN;
                end
            end
            HELD: begin
                // Any key in the held row keeps us here; the whole row must go quiet.
                if (cols == '0) begin
                    deb_cnt_next = '0;
                    state_next   = RELEASE;
                end
            end
            RELEASE: begin
                if (cols != '0) begin
                    state_next = HELD;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    row_idx_next  = row_idx_reg + 1'b1;
                    scan_cnt_next = '0;
                    deb_cnt_next  = '0;
                    state_next    = SCAN;
                end else begin
                    deb_cnt_next = deb_cnt_reg + 1'b1;
                end
            end
            default: state_next = SCAN;
        endcase
    end

    assign pop = read_ack && !fifo_empty;

    key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (KEY_CODE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({row_idx_reg, col_idx_reg}),
        .dout  (key_code),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow_reg <= 1'b1;
        end else if (pop) begin
            overflow_reg <= 1'b0;
        end
    end

    assign key_ready = !fifo_empty;
    assign overflow  = overflow_reg;
endmodule
